mem_tester: RTL and testbench

- Initiator-side block that drives the write/read port of a DEPTH-word single-port memory (behav_mem or struc_mem style).
- Memory semantics: synchronous write on the rising edge when the write enable is high; asynchronous, combinational read.
- Sequence on start:
  1. write an address-dependent pattern to every word;
  2. read every word back and compare against the expected pattern;
  3. report pass/fail, error count and first failing address.
- Sits beside the memory in top-level test harnesses as the self-checking reader for what it wrote.

---
 rtl/mem_tester_pkg.sv | 33 +++
 rtl/mem_tester_if.sv | 19 +
 rtl/mem_err_tracker.sv | 34 +++
 rtl/mem_tester.sv | 118 +++++++++++
 tb/tb_mem_tester.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_tester_pkg.sv
// Shared types, default constants and the expected-pattern helper used by the
// mem_tester memory exerciser.
package mem_tester_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int          DEF_DEPTH   = 8;
  localparam int          DEF_AW      = 3;
  localparam int          DEF_DW      = 32;
  localparam logic [31:0] DEF_PATTERN = 32'hc0000001;

  // Pattern rotated left by (addr mod DW) bits, optionally inverted.
  // Rotation is taken from the upper half of the doubled pattern shifted left.
  function automatic logic [DEF_DW-1:0] expected_word(
    input int unsigned       addr,
    input logic              inv,
    input logic [DEF_DW-1:0] pattern = DEF_PATTERN
  );
    logic [2*DEF_DW-1:0] dbl;
    logic [DEF_DW-1:0]   rot;
    int unsigned         amt;
    amt = addr % DEF_DW;
    dbl = {pattern, pattern} << amt;
    rot = dbl[2*DEF_DW-1 -: DEF_DW];
    return inv ? ~rot : rot;
  endfunction

endpackage

// File: rtl/mem_tester_if.sv
// Memory port bundle between mem_tester (master) and the memory (slave).
// Semantics: the memory captures mem_wdata at mem_addr on the rising clk edge
// whenever mem_we is high; mem_rdata is a combinational function of mem_addr
// and is valid in the same cycle the address is presented. There is no
// back-pressure: every cycle with mem_we high is one completed write.
interface mem_tester_if
  import mem_tester_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (output mem_we, output mem_addr, output mem_wdata, input  mem_rdata);
  modport slave  (input  mem_we, input  mem_addr, input  mem_wdata, output mem_rdata);
endinterface

// File: rtl/mem_err_tracker.sv
// Counts read-back mismatches (saturating) and remembers the address of the
// first mismatch seen since the last clear.
module mem_err_tracker #(
  parameter int AW = 3,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          cmp_en,
  input  logic [DW-1:0] rdata,
  input  logic [DW-1:0] expected,
  input  logic [AW-1:0] addr,
  output logic [AW:0]   err_count,
  output logic [AW-1:0] first_err_addr
);

  localparam logic [AW:0] SAT = '1;

  logic mismatch;
  assign mismatch = cmp_en && (rdata != expected);

  // Error counter and first-failure capture; a zero count marks "no error yet".
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (mismatch) begin
      if (err_count != SAT) err_count <= err_count + 1'b1;
      if (err_count == '0)  first_err_addr <= addr;
    end
  end

endmodule

// File: rtl/mem_tester.sv
// Memory exerciser: writes a rotating pattern to every word, reads it back,
// and reports pass/fail, error count and first failing address.
// Optional macro MEM_TESTER_INV_PASS_EN adds a second sweep with inverted data.
module mem_tester
  import mem_tester_pkg::*;
#(
  parameter int          DEPTH   = DEF_DEPTH,
  parameter int          AW      = DEF_AW,
  parameter int          DW      = DEF_DW,
  parameter logic [31:0] PATTERN = DEF_PATTERN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  mem_tester_if.master        mem,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [AW:0]         err_count,
  output logic [AW-1:0]       first_err_addr,
  output state_t              dbg_state
);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic          pass_q;
  logic          phase_q;
  logic          start_acc;
  logic          last_addr;
  logic [DW-1:0] exp_word;

  assign start_acc = (state_q == IDLE) && start;
  assign last_addr = (addr_q == AW'(DEPTH - 1));
  assign exp_word  = DW'(expected_word(32'(addr_q), phase_q, DEF_DW'(PATTERN)));

`ifdef MEM_TESTER_INV_PASS_EN
  // Sweep selector: 0 = true pattern, 1 = inverted pattern.
  always_ff @(posedge clk) begin
    if (reset)                                          phase_q <= 1'b0;
    else if (start_acc)                                 phase_q <= 1'b0;
    else if (state_q == READ && last_addr && !phase_q)  phase_q <= 1'b1;
  end
`else
  assign phase_q = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = WRITE;
      WRITE: if (last_addr) state_d = READ;
      READ: begin
        if (last_addr) begin
`ifdef MEM_TESTER_INV_PASS_EN
          state_d = phase_q ? DONE : WRITE;
`else
          state_d = DONE;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address counter and stored result; address wraps naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      pass_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          addr_q <= '0;
          if (start) pass_q <= 1'b0;
        end
        WRITE, READ: addr_q <= addr_q + 1'b1;
        DONE: begin
          addr_q <= '0;
          pass_q <= (err_count == '0);
        end
        default: addr_q <= '0;
      endcase
    end
  end

  // Outputs decoded from state; pass is live during the done cycle.
  always_comb begin
    mem.mem_we    = (state_q == WRITE);
    mem.mem_wdata = (state_q == WRITE) ? exp_word : '0;
    busy          = (state_q != IDLE);
    done          = (state_q == DONE);
    pass          = (state_q == DONE) ? (err_count == '0) : pass_q;
  end

  assign mem.mem_addr = addr_q;
  assign dbg_state    = state_q;

  mem_err_tracker #(.AW(AW), .DW(DW)) u_err (
    .clk            (clk),
    .reset          (reset),
    .clear          (start_acc),
    .cmp_en         (state_q == READ),
    .rdata          (mem.mem_rdata),
    .expected       (exp_word),
    .addr           (addr_q),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

endmodule

// File: tb/tb_mem_tester.sv
// Bench for mem_tester: behavioural memory with fault injection on reads and
// a reference model of writes, error count, first error and timing.
module tb_mem_tester;
  import mem_tester_pkg::*;

  localparam int DEPTH = 8;
`ifdef MEM_TESTER_INV_PASS_EN
  localparam int SWEEPS = 2;
`else
  localparam int SWEEPS = 1;
`endif
  localparam int RUN_DONE = 2 * DEPTH * SWEEPS + 1;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] first_err_addr;
  state_t     dbg_state;

  always #5 clk = ~clk;

  mem_tester_if #(.AW(3), .DW(32)) mif ();

  mem_tester dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .mem            (mif),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .dbg_state      (dbg_state)
  );

  // Behavioural memory: synchronous write, combinational read with faults.
  logic [31:0] mem_arr [DEPTH];
  logic [31:0] fault_mask [DEPTH];
  bit          force_zero = 1'b0;

  always @(posedge clk) if (mif.mem_we) mem_arr[mif.mem_addr] <= mif.mem_wdata;

  always_comb begin
    logic [31:0] rd;
    rd = mem_arr[mif.mem_addr];
    if (busy && !mif.mem_we) rd = force_zero ? 32'h0 : (rd ^ fault_mask[mif.mem_addr]);
    mif.mem_rdata = rd;
  end

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference pattern: seed rotated left by a bits, optionally inverted.
  function automatic logic [31:0] ref_word(input int a, input bit inv);
    logic [31:0] p, r;
    int s;
    p = 32'hc0000001;
    s = a % 32;
    r = (s == 0) ? p : ((p << s) | (p >> (32 - s)));
    return inv ? ~r : r;
  endfunction

  int exp_err, exp_first;

  // Expected run outcome from what the memory will return on each read.
  task automatic compute_expect();
    logic [31:0] stored, rd;
    exp_err = 0;
    exp_first = 0;
    for (int s = 0; s < SWEEPS; s++) begin
      for (int a = 0; a < DEPTH; a++) begin
        stored = ref_word(a, s != 0);
        rd = force_zero ? 32'h0 : (stored ^ fault_mask[a]);
        if (rd != stored) begin
          if (exp_err == 0) exp_first = a;
          exp_err++;
        end
      end
    end
    if (exp_err > 15) exp_err = 15;
  endtask

  task automatic clear_faults();
    force_zero = 1'b0;
    for (int a = 0; a < DEPTH; a++) fault_mask[a] = 32'h0;
  endtask

  // Full run from a start pulse; optional extra start pulse at cycle restart_at.
  task automatic run_test(input string name, input int restart_at);
    int writes, done_cycle, n_done;
    compute_expect();
    writes = 0; done_cycle = -1; n_done = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    check({name, "_busy_c1"}, 64'(busy), 64'(1));
    for (int c = 1; c <= RUN_DONE + 3; c++) begin
      if (mif.mem_we) begin
        check({name, "_waddr"}, 64'(mif.mem_addr), 64'(writes % DEPTH));
        check({name, "_wdata"}, 64'(mif.mem_wdata),
              64'(ref_word(writes % DEPTH, (writes / DEPTH) != 0)));
        writes++;
      end
      if (done) begin
        if (done_cycle < 0) begin
          done_cycle = c;
          check({name, "_pass_at_done"}, 64'(pass), 64'(exp_err == 0));
          check({name, "_err_at_done"}, 64'(err_count), 64'(exp_err));
        end
        n_done++;
      end
      start = (c == restart_at);
      @(negedge clk);
    end
    start = 1'b0;
    if (done_cycle < 0) check({name, "_done_timeout"}, 64'(0), 64'(1));
    else                check({name, "_done_cycle"}, 64'(done_cycle), 64'(RUN_DONE));
    check({name, "_done_count"}, 64'(n_done), 64'(1));
    check({name, "_writes"}, 64'(writes), 64'(DEPTH * SWEEPS));
    check({name, "_err_count"}, 64'(err_count), 64'(exp_err));
    check({name, "_first_err"}, 64'(first_err_addr), 64'(exp_first));
    check({name, "_pass"}, 64'(pass), 64'(exp_err == 0));
    check({name, "_idle"}, 64'(busy), 64'(0));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    clear_faults();
    repeat (2) @(negedge clk);
    check("rst_we", 64'(mif.mem_we), 64'(0));
    check("rst_addr", 64'(mif.mem_addr), 64'(0));
    check("rst_wdata", 64'(mif.mem_wdata), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_pass", 64'(pass), 64'(0));
    check("rst_err", 64'(err_count), 64'(0));
    check("rst_first", 64'(first_err_addr), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    reset = 1'b0;
    @(negedge clk);

    run_test("clean", -1);

    clear_faults();
    fault_mask[5] = 32'h1;
    run_test("single_fault", -1);

    clear_faults();
    force_zero = 1'b1;
    run_test("all_zero", -1);

    // Result hold after a failing run.
    begin
      int changes = 0;
      for (int c = 0; c < 20; c++) begin
        if (pass !== 1'b0 || err_count !== 4'(exp_err) || first_err_addr !== 3'(exp_first))
          changes++;
        @(negedge clk);
      end
      check("hold_changes", 64'(changes), 64'(0));
    end
    clear_faults();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    check("clr_err", 64'(err_count), 64'(0));
    check("clr_first", 64'(first_err_addr), 64'(0));
    check("clr_pass", 64'(pass), 64'(0));
    check("clr_busy", 64'(busy), 64'(1));
    repeat (RUN_DONE + 2) @(negedge clk);
    check("clr_run_pass", 64'(pass), 64'(1));

    clear_faults();
    run_test("start_busy", 4);

    // Reset mid-run at cycle 3 (WRITE, addr 2).
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_pre_addr", 64'(mif.mem_addr), 64'(2));
    check("mid_pre_we", 64'(mif.mem_we), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    check("mid_we", 64'(mif.mem_we), 64'(0));
    check("mid_busy", 64'(busy), 64'(0));
    check("mid_err", 64'(err_count), 64'(0));
    check("mid_state", 64'(dbg_state), 64'(IDLE));
    reset = 1'b0;
    begin
      int activity = 0;
      for (int c = 0; c < 20; c++) begin
        if (done || mif.mem_we || busy) activity++;
        @(negedge clk);
      end
      check("mid_quiet", 64'(activity), 64'(0));
    end
    run_test("after_reset", -1);

    // Randomized fault masks.
    for (int r = 0; r < 6; r++) begin
      clear_faults();
      for (int a = 0; a < DEPTH; a++)
        if ($urandom_range(0, 2) == 0) fault_mask[a] = 32'h1 << $urandom_range(0, 31);
      run_test($sformatf("rand%0d", r), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
